// File: rtl/tb_irq_ctrl_pkg.sv
// Shared register map, CTRL bit positions and interrupt-id constants for the
// timer/interrupt controller and its per-channel timer sub-module.
package tb_irq_ctrl_pkg;

  localparam logic [7:0] OFF_SWIRQ    = 8'h00;
  localparam logic [7:0] OFF_PENDING  = 8'h04;
  localparam logic [7:0] OFF_ENABLE   = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;

  // Channel c occupies 0x10+16*c; these are the offsets inside that window.
  localparam logic [3:0] OFF_CH_CTRL    = 4'h0;
  localparam logic [3:0] OFF_CH_COMPARE = 4'h4;
  localparam logic [3:0] OFF_CH_COUNT   = 4'h8;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_PERIODIC = 1;

  localparam int IRQ_ID_SOFTWARE  = 3;
  localparam int IRQ_ID_TIMER     = 7;
  localparam int IRQ_ID_EXTERNAL  = 11;
  localparam int IRQ_ID_FAST_BASE = 16;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_SWIRQ,
    REG_PENDING,
    REG_ENABLE,
    REG_PRESCALE,
    REG_CH_CTRL,
    REG_CH_COMPARE,
    REG_CH_COUNT
  } reg_sel_e;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/tb_irq_ctrl_timer_ch.sv
// One timer channel: free-running counter with compare match, run/periodic
// control and a single-cycle fire pulse. Bus writes override tick updates.
module tb_irq_timer_ch
  import tb_irq_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic                 ctrl_we_i,
  input  logic                 ctrl_run_i,
  input  logic                 ctrl_periodic_i,
  input  logic                 cmp_we_i,
  input  logic [CNT_WIDTH-1:0] cmp_wdata_i,
  input  logic                 cnt_we_i,
  input  logic [CNT_WIDTH-1:0] cnt_wdata_i,
  output logic                 run_o,
  output logic                 periodic_o,
  output logic [CNT_WIDTH-1:0] cmp_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 fire_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 run_q, run_d;
  logic                 periodic_q, periodic_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cmp_q, cmp_d;

  assign fire_o     = tick_i && run_q && (cnt_q == cmp_q);
  assign run_o      = run_q;
  assign periodic_o = periodic_q;
  assign cmp_o      = cmp_q;
  assign cnt_o      = cnt_q;

  always_comb begin
    run_d      = run_q;
    periodic_d = periodic_q;
    cnt_d      = cnt_q;
    cmp_d      = cmp_q;
    if (tick_i && run_q) begin
      if (cnt_q == cmp_q) begin
        if (periodic_q) cnt_d = '0;
        else            run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    // Software writes land last so they win over reload and auto-stop.
    if (ctrl_we_i) begin
      run_d      = ctrl_run_i;
      periodic_d = ctrl_periodic_i;
    end
    if (cmp_we_i) cmp_d = cmp_wdata_i;
    if (cnt_we_i) cnt_d = cnt_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      periodic_q <= 1'b0;
      cnt_q      <= '0;
      cmp_q      <= '0;
    end else begin
      run_q      <= run_d;
      periodic_q <= periodic_d;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
    end
  end

endmodule

// File: rtl/tb_irq_ctrl.sv
// Timer/interrupt controller with bus slave, pending/enable and exploded irq
// lines. Define TB_IRQ_CTRL_PRESCALER_EN to add the shared tick prescaler.
module tb_irq_ctrl
  import tb_irq_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  output logic        irq_software_o,
  output logic        irq_timer_o,
  output logic        irq_external_o,
  output logic [14:0] irq_fast_o
);

  localparam logic [31:0] FAST_MASK  = ((32'h1 << (NUM_CH-1)) - 32'h1) << IRQ_ID_FAST_BASE;
  localparam logic [31:0] VALID_MASK = FAST_MASK | (32'h1 << IRQ_ID_SOFTWARE) |
                                       (32'h1 << IRQ_ID_TIMER) | (32'h1 << IRQ_ID_EXTERNAL);

  logic [31:0] unused_addr;
  assign unused_addr = addr_i;

  reg_sel_e    sel;
  logic [3:0]  ch_idx;
  logic        wr, tick;
  logic [31:0] wmask, active, hw_set, prescale_rd, rd_mux;

  logic [1:0]  swirq_q, swirq_d;
  logic [31:0] enable_q, enable_d, pending_q, pending_d, rdata_q, rdata_d;
  logic        rvalid_q, irq_q, irq_d;
  logic [4:0]  irq_id_q, irq_id_d;

  logic [NUM_CH-1:0]                run, periodic, fire;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cmp, cnt;

  assign gnt_o = req_i & rst_ni;
  assign wr    = req_i & we_i;
  assign wmask = be_mask(be_i);

  always_comb begin
    sel    = REG_NONE;
    ch_idx = addr_i[7:4] - 4'd1;
    if (addr_i[1:0] == 2'b00) begin
      if (addr_i[7:4] == 4'h0) begin
        if      (addr_i[7:0] == OFF_SWIRQ)    sel = REG_SWIRQ;
        else if (addr_i[7:0] == OFF_PENDING)  sel = REG_PENDING;
        else if (addr_i[7:0] == OFF_ENABLE)   sel = REG_ENABLE;
        else if (addr_i[7:0] == OFF_PRESCALE) sel = REG_PRESCALE;
      end else if (int'(ch_idx) < NUM_CH) begin
        if      (addr_i[3:0] == OFF_CH_CTRL)    sel = REG_CH_CTRL;
        else if (addr_i[3:0] == OFF_CH_COMPARE) sel = REG_CH_COMPARE;
        else if (addr_i[3:0] == OFF_CH_COUNT)   sel = REG_CH_COUNT;
      end
    end
  end

`ifdef TB_IRQ_CTRL_PRESCALER_EN
  logic [15:0] prescale_q, prescale_d, div_q, div_d;

  // The divider parks at zero while no channel runs, so a fresh start always
  // sees a full PRESCALE+1 period before its first tick.
  always_comb begin
    prescale_d = prescale_q;
    if (wr && sel == REG_PRESCALE)
      prescale_d = (prescale_q & ~wmask[15:0]) | (wdata_i[15:0] & wmask[15:0]);
    tick  = (div_q >= prescale_q);
    div_d = (tick || !(|run)) ? 16'h0 : div_q + 16'h1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q <= 16'h0;
      div_q      <= 16'h0;
    end else begin
      prescale_q <= prescale_d;
      div_q      <= div_d;
    end
  end

  assign prescale_rd = {16'h0, prescale_q};
`else
  assign tick        = 1'b1;
  assign prescale_rd = 32'h0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_ch;
    assign wr_ch = wr && (ch_idx == 4'(c));

    tb_irq_timer_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .tick_i          (tick),
      .ctrl_we_i       (wr_ch && sel == REG_CH_CTRL && be_i[0]),
      .ctrl_run_i      (wdata_i[CTRL_RUN]),
      .ctrl_periodic_i (wdata_i[CTRL_PERIODIC]),
      .cmp_we_i        (wr_ch && sel == REG_CH_COMPARE),
      .cmp_wdata_i     ((cmp[c] & ~wmask[CNT_WIDTH-1:0]) | (wdata_i[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0])),
      .cnt_we_i        (wr_ch && sel == REG_CH_COUNT),
      .cnt_wdata_i     ((cnt[c] & ~wmask[CNT_WIDTH-1:0]) | (wdata_i[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0])),
      .run_o           (run[c]),
      .periodic_o      (periodic[c]),
      .cmp_o           (cmp[c]),
      .cnt_o           (cnt[c]),
      .fire_o          (fire[c])
    );
  end

  always_comb begin
    hw_set = '0;
    hw_set[IRQ_ID_TIMER] = fire[0];
    for (int c = 1; c < NUM_CH; c++) hw_set[IRQ_ID_FAST_BASE + c - 1] = fire[c];

    swirq_d = swirq_q;
    if (wr && sel == REG_SWIRQ && be_i[0]) swirq_d = wdata_i[1:0];

    enable_d = enable_q;
    if (wr && sel == REG_ENABLE)
      enable_d = ((enable_q & ~wmask) | (wdata_i & wmask)) & VALID_MASK;

    // Clears first, then level/hardware sets, so a same-cycle firing sticks.
    pending_d = pending_q;
    if (wr && sel == REG_PENDING) pending_d = pending_d & ~(wdata_i & wmask);
    if (irq_ack_i) pending_d[irq_id_i] = 1'b0;
    pending_d[IRQ_ID_SOFTWARE] = swirq_q[0];
    pending_d[IRQ_ID_EXTERNAL] = swirq_q[1];
    pending_d = (pending_d | hw_set) & VALID_MASK;
  end

  assign active         = pending_q & enable_q;
  assign irq_software_o = active[IRQ_ID_SOFTWARE];
  assign irq_timer_o    = active[IRQ_ID_TIMER];
  assign irq_external_o = active[IRQ_ID_EXTERNAL];
  assign irq_fast_o     = active[IRQ_ID_FAST_BASE +: 15];

  always_comb begin
    irq_d    = |active;
    irq_id_d = '0;
    for (int i = 0; i < 32; i++) if (active[i]) irq_id_d = 5'(i);
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_SWIRQ:    rd_mux = {30'h0, swirq_q};
      REG_PENDING:  rd_mux = pending_q;
      REG_ENABLE:   rd_mux = enable_q;
      REG_PRESCALE: rd_mux = prescale_rd;
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_idx == 4'(c)) begin
            if (sel == REG_CH_CTRL) begin
              rd_mux[CTRL_RUN]      = run[c];
              rd_mux[CTRL_PERIODIC] = periodic[c];
            end else if (sel == REG_CH_COMPARE) begin
              rd_mux = 32'(cmp[c]);
            end else if (sel == REG_CH_COUNT) begin
              rd_mux = 32'(cnt[c]);
            end
          end
        end
      end
    endcase
    rdata_d = (req_i && !we_i) ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      swirq_q   <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      swirq_q   <= swirq_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= req_i;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: doc/tb_irq_ctrl.md
TB_IRQ_CTRL -- requirements
Module: tb_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of timer channels (1..15).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, counter/compare width (8..32).
REQ-003 SHALL have port clk_i  input  1  sole clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_i/we_i  input  1 each; addr_i  input  32; be_i  input  4; wdata_i  input  32; together a data-bus slave request.
REQ-006 SHALL have ports gnt_o/rvalid_o  output  1 each; rdata_o  output  32; together the slave response.
REQ-007 SHALL have ports irq_ack_i  input  1; irq_id_i  input  5; together the core acknowledge.
REQ-008 SHALL have ports irq_o  output  1; irq_id_o  output  5; together the legacy request.
REQ-009 SHALL have ports irq_software_o, irq_timer_o, irq_external_o  output  1 each; irq_fast_o  output  15; together the exploded interrupt lines.

Function
REQ-010 SHALL assert gnt_o combinationally equal to req_i, pulse rvalid_o exactly one cycle after each grant (reads and writes), and provide registered rdata_o.
REQ-011 SHALL decode addr_i[7:0] only: 0x00 SWIRQ (bit0 software, bit1 external), 0x04 PENDING (W1C), 0x08 ENABLE, 0x0C PRESCALE, 0x10+16*c CTRL (bit0 run, bit1 periodic), 0x14+16*c COMPARE, 0x18+16*c COUNT.
REQ-012 SHALL honour be_i per byte on writes; unmapped or c>=NUM_CH addresses SHALL read 0 with writes ignored.
REQ-013 SHALL use pending/enable bit positions equal to irq id: software 3, timer 7, external 11, fast k at 16+k.
REQ-014 SHALL increment COUNT of channel c by one per tick while CTRL.run=1, wrapping at 2^CNT_WIDTH.
REQ-015 SHALL, on a tick where COUNT==COMPARE: set the channel's pending bit; if periodic, load COUNT=0; else clear run and hold COUNT.
REQ-016 SHALL route channel 0 to pending bit 7 and channel c>=1 to pending bit 16+c-1.
REQ-017 SHALL level-drive SWIRQ bits into pending bits 3 and 11 each cycle.
REQ-018 SHALL drive each exploded line as pending AND enable of its bit; unused fast lines SHALL be 0.
REQ-019 SHALL drive irq_o as OR of all exploded lines and irq_id_o as the highest active id, 0 when none, both registered.
REQ-020 SHALL clear the pending bit indexed by irq_id_i when irq_ack_i=1.
REQ-021 SHALL let a hardware set of a pending bit win over a same-cycle ack or W1C of that bit.
REQ-022 SHALL let a bus write to COUNT/CTRL win over a same-cycle increment, reload or auto-clear.
REQ-023 SHALL give COMPARE=0 with periodic=1 a firing on every tick.

Reset
REQ-024 SHALL asynchronously on rst_ni=0 clear all registers, counters, pending and enable bits, set PRESCALE=0, and drive every output to 0.
REQ-025 SHALL abandon an outstanding rvalid on reset mid-transaction; rvalid_o SHALL be 0 the cycle after release.

Configuration
REQ-026 SHALL, with TB_IRQ_CTRL_PRESCALER_EN defined, implement a 16-bit PRESCALE register and a shared divider producing one tick every PRESCALE+1 cycles.
REQ-027 SHALL, without TB_IRQ_CTRL_PRESCALER_EN, tick every cycle, read PRESCALE as 0 and ignore writes to it.

Structure
REQ-028 SHALL place register offsets, CTRL bit positions and irq-id constants in package tb_irq_ctrl_pkg.
REQ-029 SHALL implement one channel (counter, compare, run/periodic, fire pulse, bus-override) as sub-module tb_irq_timer_ch, generated NUM_CH times.

Verification
REQ-030 SHALL cover: COMPARE0=5, ENABLE=0x80, CTRL0=0x1 -> irq_timer_o rises after 6 ticks, run clears, COUNT0 holds 5.
REQ-031 SHALL cover: CTRL1=0x3, COMPARE1=3, ENABLE bit16 -> irq_fast_o[0] pending every 4 ticks; ack with id 16 clears it until next firing.
REQ-032 SHALL cover: timer and fast[2] both pending and enabled -> irq_id_o=18; after ack 18, irq_id_o=7.
REQ-033 SHALL cover: ack id 7 in the same cycle channel 0 fires -> pending bit 7 stays 1.
REQ-034 SHALL cover: with macro, PRESCALE=3, COMPARE0=2 -> firing after 12 cycles; without macro, PRESCALE reads 0 and firing occurs after 3 cycles.
REQ-035 SHALL cover: rst_ni low while rvalid pending and counters running -> all outputs 0, COUNT reads 0 after release.
